// File: rtl/sn74x161.sv
// sn74x161: parametrised synchronous up/down counter modelled on the
// 74x160/161/191 family. Asynchronous active-low clear, synchronous
// active-low parallel load, ENP/ENT count enables and a combinational
// ripple-carry/borrow output so instances cascade like the physical parts.
module sn74x161 #(
    parameter int              WIDTH   = 4,
    parameter longint unsigned MODULUS = 16
) (
    input  logic             CLK,
    input  logic             CLR_n,
    input  logic             LOAD_n,
    input  logic [WIDTH-1:0] D,
    input  logic             ENP,
    input  logic             ENT,
    input  logic             UP,
    output logic [WIDTH-1:0] Q,
    output logic             RCO
);

    // Modulus and terminal count carried in WIDTH+1 bits so that
    // MODULUS = 2^WIDTH is representable and the increment cannot overflow.
    localparam logic [WIDTH:0] LP_MOD = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0] LP_MAX = LP_MOD - (WIDTH+1)'(1);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH:0]   w_q_ext;
    logic [WIDTH:0]   w_d_ext;
    logic [WIDTH:0]   w_inc;
    logic [WIDTH-1:0] w_dec;
    logic             w_terminal;

    // Next-state selection: load beats count, count beats hold.
    always_comb begin
        w_q_next = r_q;
        w_q_ext  = {1'b0, r_q};
        w_d_ext  = {1'b0, D};
        w_inc    = w_q_ext + (WIDTH+1)'(1);
        w_dec    = r_q - WIDTH'(1);
        if (!LOAD_n) begin
            // Out-of-range load data is forced to zero.
            if (w_d_ext < LP_MOD) begin
                w_q_next = D;
            end else begin
                w_q_next = '0;
            end
        end else if (ENP && ENT) begin
            if (UP) begin
                if (w_inc >= LP_MOD) begin
                    w_q_next = '0;
                end else begin
                    w_q_next = w_inc[WIDTH-1:0];
                end
            end else begin
                if (r_q == '0) begin
                    w_q_next = LP_MAX[WIDTH-1:0];
                end else begin
                    w_q_next = w_dec;
                end
            end
        end else begin
            w_q_next = r_q;
        end
    end

    // Counter state: clear is asynchronous and overrides every edge while low.
    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            r_q <= '0;
        end else begin
            r_q <= w_q_next;
        end
    end

    // Terminal detect and ripple carry/borrow, combinational from Q, UP and ENT.
    always_comb begin
        w_terminal = 1'b0;
        if (UP) begin
            w_terminal = ({1'b0, r_q} == LP_MAX);
        end else begin
            w_terminal = (r_q == '0);
        end
        RCO = ENT & w_terminal;
    end

    assign Q = r_q;

endmodule

// File: tb/tb_sn74x161.sv
// Directed bench for sn74x161: decade instance, two-stage decade cascade
// and a 4-bit binary instance, all on one clock.
module tb_sn74x161;

    logic clk;
    int   n_checks;
    int   n_pass;

    // Decade instance controls
    logic       clr_n, load_n, enp, ent, up;
    logic [3:0] d;
    logic [3:0] q;
    logic       rco;

    // Cascade controls
    logic       c_clr_n, c_enp, c_up;
    logic [3:0] c_q0, c_q1;
    logic       c_rco0, c_rco1;

    // Binary instance controls
    logic       b_clr_n, b_enp;
    logic [3:0] b_q;
    logic       b_rco;

    sn74x161 #(.WIDTH(4), .MODULUS(10)) u_dec (
        .CLK(clk), .CLR_n(clr_n), .LOAD_n(load_n), .D(d),
        .ENP(enp), .ENT(ent), .UP(up), .Q(q), .RCO(rco)
    );

    sn74x161 #(.WIDTH(4), .MODULUS(10)) u_cas0 (
        .CLK(clk), .CLR_n(c_clr_n), .LOAD_n(1'b1), .D(4'd0),
        .ENP(c_enp), .ENT(1'b1), .UP(c_up), .Q(c_q0), .RCO(c_rco0)
    );

    sn74x161 #(.WIDTH(4), .MODULUS(10)) u_cas1 (
        .CLK(clk), .CLR_n(c_clr_n), .LOAD_n(1'b1), .D(4'd0),
        .ENP(c_enp), .ENT(c_rco0), .UP(c_up), .Q(c_q1), .RCO(c_rco1)
    );

    sn74x161 #(.WIDTH(4), .MODULUS(16)) u_bin (
        .CLK(clk), .CLR_n(b_clr_n), .LOAD_n(1'b1), .D(4'd0),
        .ENP(b_enp), .ENT(1'b1), .UP(1'b1), .Q(b_q), .RCO(b_rco)
    );

    // Free-running clock, period 10, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_q;
        n_checks = 0;
        n_pass   = 0;
        clr_n = 1'b0; load_n = 1'b1; d = 4'd0; enp = 1'b1; ent = 1'b1; up = 1'b1;
        c_clr_n = 1'b0; c_enp = 1'b1; c_up = 1'b1;
        b_clr_n = 1'b0; b_enp = 1'b1;

        // Reset value and RCO in both directions without a clock
        #2;
        check("reset_q", q, 0);
        check("reset_rco_up", rco, 0);
        up = 1'b0;
        #1;
        check("reset_rco_down", rco, 1);
        up = 1'b1;
        #1;

        // Clear holds through a rising edge, even with load requested
        load_n = 1'b0; d = 4'd5;
        tick();
        check("clr_beats_load", q, 0);
        load_n = 1'b1;

        // Release clear between edges, then count up through the wrap
        @(negedge clk);
        clr_n = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            exp_q = i % 10;
            check("up_q", q, exp_q);
            check("up_rco", rco, (exp_q == 9) ? 1 : 0);
        end

        // Load 3, then count down through the wrap
        load_n = 1'b0; d = 4'd3;
        tick();
        check("load3", q, 3);
        load_n = 1'b1;
        up = 1'b0;
        #1;
        check("down_rco_at3", rco, 0);
        exp_q = 3;
        for (int i = 0; i < 5; i++) begin
            tick();
            exp_q = (exp_q == 0) ? 9 : exp_q - 1;
            check("down_q", q, exp_q);
            check("down_rco", rco, (exp_q == 0) ? 1 : 0);
        end

        // Illegal load value is forced to zero
        load_n = 1'b0; d = 4'd12;
        tick();
        check("load_illegal", q, 0);
        check("load_illegal_rco", rco, 1);

        // ENP low holds; RCO still asserts at terminal count
        up = 1'b1; enp = 1'b0; d = 4'd9;
        tick();
        check("load9_enp0", q, 9);
        load_n = 1'b1;
        tick();
        check("enp0_hold", q, 9);
        check("enp0_rco", rco, 1);

        // ENT low holds and suppresses RCO
        ent = 1'b0; enp = 1'b1;
        #1;
        check("ent0_rco", rco, 0);
        tick();
        check("ent0_hold", q, 9);

        // Load wins over count
        ent = 1'b1; load_n = 1'b0; d = 4'd5;
        tick();
        check("load_beats_count", q, 5);

        // Async clear mid-count at Q = 6
        d = 4'd6;
        tick();
        check("load6", q, 6);
        load_n = 1'b1;
        clr_n = 1'b0;
        #1;
        check("async_clear", q, 0);
        #3;
        clr_n = 1'b1;
        tick();
        check("after_clear", q, 1);

        // Cascade: 25 up then 26 down
        @(negedge clk);
        c_clr_n = 1'b1;
        for (int i = 0; i < 25; i++) tick();
        check("cas_up_q1", c_q1, 2);
        check("cas_up_q0", c_q0, 5);
        c_up = 1'b0;
        for (int i = 0; i < 26; i++) tick();
        check("cas_down_q1", c_q1, 9);
        check("cas_down_q0", c_q0, 9);

        // Binary modulus 16: full cycle back to zero
        @(negedge clk);
        b_clr_n = 1'b1;
        #1;
        check("bin_start", b_q, 0);
        for (int i = 1; i <= 16; i++) begin
            tick();
            exp_q = i % 16;
            check("bin_q", b_q, exp_q);
            check("bin_rco", b_rco, (exp_q == 15) ? 1 : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sn74x161.md
# sn74x161

Parametrised synchronous counter model for the 74-series library. It generalises the '160/'161 (decade and 4-bit binary) and adds the up/down mode of the '191 to a single block with configurable width and modulus. It keeps the '161 asynchronous clear, synchronous parallel load, ENP/ENT enables and ripple-carry output (RCO), so multiple instances cascade exactly like the physical parts. It sits alongside the combinational gate models and is exercised by the same pass/fail-counting bench style.

## Interface

Parameters:
- WIDTH, 4, counter width in bits (1..32).
- MODULUS, 16, count length; Q cycles 0..MODULUS-1. Legal range is 2..2^WIDTH. Use 10 for '160 behaviour and 16 for '161 behaviour.

Ports:
- CLK  in  1  clock; all state changes except clear occur on the rising edge.
- CLR_n  in  1  asynchronous, active-low clear. One clock; reset is asynchronous and active-low.
- LOAD_n  in  1  synchronous, active-low parallel load.
- D  in  WIDTH  parallel load data.
- ENP  in  1  count enable (parallel); gates counting only.
- ENT  in  1  count enable (trickle); gates counting and RCO.
- UP  in  1  direction: 1 = count up, 0 = count down.
- Q  out  WIDTH  counter state.
- RCO  out  1  ripple carry/borrow; combinational.

## Operation

- Priority, highest first: CLR_n, then LOAD_n, then count, then hold.
- CLR_n low: Q = 0 immediately, independent of CLK. Q stays 0 while CLR_n is low, and any rising edge during that time is ignored.
- LOAD_n low at a rising edge:
  - If D < MODULUS, Q <= D.
  - If D >= MODULUS, Q <= 0 (illegal load value is forced to zero).
  - Load ignores ENP, ENT and UP.
- LOAD_n high, ENP = 1 and ENT = 1 at a rising edge:
  - UP = 1: Q <= Q+1. From MODULUS-1, Q wraps to 0.
  - UP = 0: Q <= Q-1. From 0, Q wraps to MODULUS-1.
- Any other combination at a rising edge: Q holds.
- RCO = ENT & terminal, where terminal is (Q == MODULUS-1) when UP = 1 and (Q == 0) when UP = 0. RCO does not depend on ENP, LOAD_n or CLK.
- Cascading: stage k RCO drives stage k+1 ENT, and all stages share CLK, CLR_n, ENP and UP. The cascade then counts as a single MODULUS^n counter in either direction.
- Arithmetic is performed in WIDTH+1 bits before the wrap compare, so MODULUS = 2^WIDTH does not overflow.
- Changing UP mid-count takes effect at the next edge; there is no dead cycle.

## Timing

- Reset values: Q = 0. RCO = ENT & ~UP, because Q = 0 is terminal in down mode.
- Clear is asynchronous on assert. On deassert, the first rising edge with CLR_n already high is the first active edge. The bench must not release CLR_n coincident with a rising edge.
- Load and count latency is 1 cycle: Q updates on the same rising edge at which the inputs are sampled.
- RCO is combinational with zero-cycle latency, and follows Q, UP and ENT within the same delta/timestep.
- Simultaneous events:
  - LOAD_n low with ENP = ENT = 1: load wins.
  - CLR_n low with LOAD_n low: clear wins.
- Reset mid-operation: Q goes to 0 at once, and the count resumes from 0 after release. No state survives the clear.

## Test plan

All scenarios use WIDTH = 4 and MODULUS = 10 unless stated.

- Reset value: CLR_n = 0 with UP = 1, ENT = 1 -> Q = 0 and RCO = 0. Set UP = 0 -> RCO = 1 with no clock.
- Up-count wrap: release CLR_n, ENP = ENT = UP = 1, 12 clocks -> Q steps 1..9, 0, 1, 2. RCO = 1 only while Q = 9.
- Down-count wrap and load:
  - Load D = 3, then UP = 0 for 5 clocks -> Q = 3, 2, 1, 0, 9, 8. RCO = 1 only while Q = 0.
  - Load D = 12 (illegal) -> Q = 0.
- Enables and priority:
  - ENP = 0, ENT = 1 -> Q holds and RCO still asserts at 9.
  - ENT = 0 -> Q holds and RCO = 0.
  - LOAD_n = 0, D = 5 with ENP = ENT = 1 -> Q = 5 (load wins).
- Async clear mid-count: at Q = 6, pulse CLR_n low for half a cycle between edges -> Q = 0 immediately. The next edge after release gives Q = 1.
- Cascade: two instances, MODULUS = 10, stage 0 RCO wired to stage 1 ENT, UP = 1.
  - 25 clocks from 0 -> {Q1, Q0} = {2, 5}.
  - Then UP = 0 for 26 clocks -> {9, 9}, i.e. a borrow through 00.
- Binary mode: WIDTH = 4, MODULUS = 16, 16 clocks up -> Q returns to 0 with no overflow. RCO = 1 only at Q = 15.
